desc_slave_sequencer: RTL and testbench
=======================================

Name: desc_slave_sequencer

Overview:
Responder (slave) end of the valid/ready descriptor channel: valid, ready, length[3:0], source[7:0], destination[7:0].
- Accepts descriptors into a small FIFO.
- Expands each descriptor into `length` per-beat address pairs (source+i, destination+i) on a valid/ready beat stream that feeds the downstream transfer engine.
- Pulses `desc_done` when a descriptor completes.

Parameters:
FIFO_DEPTH, 4, descriptor FIFO entries; power of 2, >= 2
ADDR_W, 8, width of source/destination/beat addresses
LEN_W, 4, width of length field

Ports:
clk  input  1  clock, rising edge
nrst  input  1  asynchronous active-low reset
valid  input  1  descriptor valid from master
ready  output  1  descriptor accept
length  input  LEN_W  beat count; 0 = empty descriptor
source  input  ADDR_W  start source address
destination  input  ADDR_W  start destination address
beat_valid  output  1  beat pair valid
beat_ready  input  1  downstream accepts beat
beat_src  output  ADDR_W  source address of current beat
beat_dst  output  ADDR_W  destination address of current beat
beat_last  output  1  current beat is final beat of descriptor
desc_done  output  1  one-cycle pulse, descriptor retired
fifo_level  output  clog2(FIFO_DEPTH)+1  entries held
busy  output  1  high while state is RUN or FIFO is non-empty

Behaviour:
- Reset (nrst low, async): FIFO empty, state IDLE. All outputs 0, including ready, which is forced 0 while nrst is low.
- ready = (fifo_level != FIFO_DEPTH) and nrst. Derived from the registered count only; a same-cycle pop does not raise ready.
- Accept on a rising edge with valid && ready: {length, source, destination} is written to the FIFO tail.
- A simultaneous push and pop leaves the level unchanged.
- The master must hold valid and data stable until accepted. The block does not check this.
- FSM states: IDLE, RUN.
- IDLE with FIFO non-empty: pop the head at the edge.
  - If length != 0: load cur_src = source, cur_dst = destination, remaining = length, and go to RUN.
  - If length == 0: no beats are issued; desc_done pulses in the next cycle; stay in IDLE.
- RUN:
  - beat_valid = 1, beat_src = cur_src, beat_dst = cur_dst, beat_last = (remaining == 1).
  - Outputs are held stable until beat_ready.
  - On beat_valid && beat_ready: cur_src++, cur_dst++ (both wrap mod 2^ADDR_W, e.g. 0xFF -> 0x00) and remaining--.
  - On the handshake with beat_last: go to IDLE and pulse desc_done in the next cycle.
- IDLE always takes at least one cycle, so there is exactly one bubble between consecutive descriptors.
- Latency: a descriptor accepted at edge N into an empty FIFO while IDLE is popped at edge N+1, and beat_valid is high in the cycle after edge N+1.
- Maximum descriptor is 15 beats (length = 4'hF).
- beat_valid, beat_src, beat_dst, beat_last, desc_done, ready and busy are registered or derived only from registered state. There is no combinational path from valid to beat_*.
- nrst asserted mid-descriptor: the in-flight beat and all queued descriptors are discarded with no desc_done. After release the block is in IDLE with ready = 1 on the first clock.
- beat_ready held low indefinitely: RUN stalls, and the FIFO keeps accepting until full, after which ready = 0.

Test Plan:
1. Reset then single descriptor {len=3, src=0x10, dst=0x80}, beat_ready=1 -> beats (0x10,0x80), (0x11,0x81), (0x12,0x82). beat_last only on the third beat. desc_done pulses once, one cycle after the third handshake.
2. Wrap: {len=4, src=0xFE, dst=0xFF} -> src 0xFE,0xFF,0x00,0x01 and dst 0xFF,0x00,0x01,0x02.
3. Back-pressure/full: beat_ready=0 and 5 descriptors offered (FIFO_DEPTH=4).
   - First descriptor popped into RUN.
   - Next 4 fill the FIFO; ready drops after the 5th accept; fifo_level=4.
   - Release beat_ready: every descriptor drains in order, with a one-cycle bubble between descriptors.
4. Zero length: {len=0, src=0x20, dst=0x40} followed by {len=1, src=0x30, dst=0x50} -> no beat for the first, desc_done pulse, then a single beat (0x30,0x50) with beat_last=1 and a second desc_done.
5. Random beat_ready toggling on {len=15, src=0x00, dst=0xF0} -> beat outputs stable while beat_ready=0. Exactly 15 handshakes, with beat_dst ending at 0xFE.
6. nrst pulsed low mid-beat of a len=8 descriptor with 2 queued -> all outputs 0 immediately. After release: fifo_level=0, busy=0, ready=1, and no desc_done is ever emitted for the discarded descriptors.

Source files
------------

// File: rtl/desc_slave_sequencer.sv
// Descriptor responder: queues {length, source, destination} descriptors
// in a FIFO and expands each one into a stream of per-beat address pairs.
//
// Ports:
//   clk, nrst                 clock (rising edge), async active-low reset
//   valid/ready               descriptor handshake from the master
//   length/source/destination descriptor fields (length 0 = no beats)
//   beat_valid/beat_ready     beat handshake to the transfer engine
//   beat_src/beat_dst         addresses of the current beat
//   beat_last                 current beat is the final one of its descriptor
//   desc_done                 one-cycle pulse when a descriptor retires
//   fifo_level                descriptors currently queued
//   busy                      expanding a descriptor or FIFO non-empty
module desc_slave_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8,
    parameter int LEN_W      = 4
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          valid,
    output logic                          ready,
    input  logic [LEN_W-1:0]              length,
    input  logic [ADDR_W-1:0]             source,
    input  logic [ADDR_W-1:0]             destination,
    output logic                          beat_valid,
    input  logic                          beat_ready,
    output logic [ADDR_W-1:0]             beat_src,
    output logic [ADDR_W-1:0]             beat_dst,
    output logic                          beat_last,
    output logic                          desc_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
    } desc_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    desc_t              mem_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_q, wr_d;
    logic [PW-1:0]      rd_q, rd_d;
    logic [PW:0]        cnt_q, cnt_d;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  src_q, src_d;
    logic [ADDR_W-1:0]  dst_q, dst_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               done_q, done_d;

    logic               push;
    logic               pop;
    logic               run;
    desc_t              head;

    // ready follows the registered level only, so a pop in the same
    // cycle never opens a slot early; reset forces it low.
    assign ready = nrst && (cnt_q != FULL_LVL);
    assign push  = valid && ready;
    assign pop   = (state_q == IDLE) && (cnt_q != '0);
    assign head  = mem_q[rd_q];
    assign run   = (state_q == RUN);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= '{len: length, src: source, dst: destination};
        end
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            wr_d = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + (PW+1)'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    if (head.len != '0) begin
                        src_d   = head.src;
                        dst_d   = head.dst;
                        rem_d   = head.len;
                        state_d = RUN;
                    end else begin
                        // empty descriptor retires without any beat
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (beat_ready) begin
                    src_d = src_q + ADDR_W'(1);
                    dst_d = dst_q + ADDR_W'(1);
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign beat_valid = run;
    assign beat_src   = run ? src_q : '0;
    assign beat_dst   = run ? dst_q : '0;
    assign beat_last  = run && (rem_q == LEN_W'(1));
    assign desc_done  = done_q;
    assign fifo_level = cnt_q;
    assign busy       = run || (cnt_q != '0);

endmodule

// File: tb/tb_desc_slave_sequencer.sv
// Directed bench for desc_slave_sequencer.
// Inputs change on the falling edge; the monitor samples 2 ns later.
module tb_desc_slave_sequencer;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       valid = 1'b0;
    logic       ready;
    logic [3:0] length = '0;
    logic [7:0] source = '0;
    logic [7:0] destination = '0;
    logic       beat_valid;
    logic       beat_ready = 1'b0;
    logic [7:0] beat_src;
    logic [7:0] beat_dst;
    logic       beat_last;
    logic       desc_done;
    logic [2:0] fifo_level;
    logic       busy;

    desc_slave_sequencer #(
        .FIFO_DEPTH(4),
        .ADDR_W(8),
        .LEN_W(4)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .valid(valid),
        .ready(ready),
        .length(length),
        .source(source),
        .destination(destination),
        .beat_valid(beat_valid),
        .beat_ready(beat_ready),
        .beat_src(beat_src),
        .beat_dst(beat_dst),
        .beat_last(beat_last),
        .desc_done(desc_done),
        .fifo_level(fifo_level),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] s;
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t      exq[$];
    beat_t      e;
    int         hs_cnt = 0;
    int         done_cnt = 0;
    int         cyc = 0;
    int         hs_cyc[$];
    logic [7:0] last_dst = '0;
    logic       pst = 1'b0;
    logic [7:0] ps, pd;
    logic       pl;

    task automatic push_beat(input logic [7:0] s, input logic [7:0] d,
                             input logic l);
        beat_t b;
        b.s = s;
        b.d = d;
        b.l = l;
        exq.push_back(b);
    endtask

    // Beat scoreboard, done counter and stall-stability monitor.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!nrst) begin
                pst = 1'b0;
            end else begin
                if (pst) begin
                    check("stall_vld", beat_valid, 1);
                    check("stall_src", beat_src, ps);
                    check("stall_dst", beat_dst, pd);
                    check("stall_last", beat_last, pl);
                end
                if (desc_done) done_cnt++;
                if (beat_valid && beat_ready) begin
                    hs_cnt++;
                    hs_cyc.push_back(cyc);
                    last_dst = beat_dst;
                    check("exp_avail", exq.size() != 0, 1);
                    if (exq.size() != 0) begin
                        e = exq.pop_front();
                        check("beat_src", beat_src, e.s);
                        check("beat_dst", beat_dst, e.d);
                        check("beat_last", beat_last, e.l);
                    end
                end
                pst = beat_valid && !beat_ready;
                ps  = beat_src;
                pd  = beat_dst;
                pl  = beat_last;
            end
        end
    end

    task automatic send(input logic [3:0] l, input logic [7:0] s,
                        input logic [7:0] d);
        valid       = 1'b1;
        length      = l;
        source      = s;
        destination = d;
        for (int i = 0; i < 64; i++) begin
            if (ready) begin
                @(negedge clk);
                valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check("send_timeout", ready, 1);
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!busy && !beat_valid) break;
        end
        check("idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    int d0, h0;
    int gaps[8] = '{1, 2, 2, 1, 1, 2, 2, 1};

    initial begin
        // reset state
        #1 nrst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_bv", beat_valid, 0);
        check("rst_lvl", fifo_level, 0);
        check("rst_busy", busy, 0);
        check("rst_done", desc_done, 0);
        nrst = 1'b1;
        #1;
        check("rel_ready", ready, 1);
        @(negedge clk);

        // 1: single descriptor, latency and beat timing
        beat_ready = 1'b1;
        push_beat(8'h10, 8'h80, 1'b0);
        push_beat(8'h11, 8'h81, 1'b0);
        push_beat(8'h12, 8'h82, 1'b1);
        d0 = done_cnt;
        send(4'd3, 8'h10, 8'h80);
        check("t1_lvl1", fifo_level, 1);
        check("t1_bv_pre", beat_valid, 0);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_bv", beat_valid, 1);
        check("t1_src0", beat_src, 8'h10);
        check("t1_dst0", beat_dst, 8'h80);
        check("t1_last0", beat_last, 0);
        check("t1_lvl0", fifo_level, 0);
        @(negedge clk);
        check("t1_src1", beat_src, 8'h11);
        check("t1_last1", beat_last, 0);
        @(negedge clk);
        check("t1_src2", beat_src, 8'h12);
        check("t1_last2", beat_last, 1);
        @(negedge clk);
        check("t1_bv_end", beat_valid, 0);
        check("t1_done_hi", desc_done, 1);
        @(negedge clk);
        check("t1_done_lo", desc_done, 0);
        check("t1_done_cnt", done_cnt - d0, 1);

        // 2: address wrap
        push_beat(8'hFE, 8'hFF, 1'b0);
        push_beat(8'hFF, 8'h00, 1'b0);
        push_beat(8'h00, 8'h01, 1'b0);
        push_beat(8'h01, 8'h02, 1'b1);
        d0 = done_cnt;
        h0 = hs_cnt;
        send(4'd4, 8'hFE, 8'hFF);
        wait_idle(60);
        check("t2_hs", hs_cnt - h0, 4);
        check("t2_done", done_cnt - d0, 1);
        check("t2_drain", exq.size(), 0);

        // 3: back-pressure until full, then in-order drain
        beat_ready = 1'b0;
        push_beat(8'h00, 8'h40, 1'b0);
        push_beat(8'h01, 8'h41, 1'b1);
        push_beat(8'h10, 8'h50, 1'b1);
        push_beat(8'h20, 8'h60, 1'b0);
        push_beat(8'h21, 8'h61, 1'b0);
        push_beat(8'h22, 8'h62, 1'b1);
        push_beat(8'h30, 8'h70, 1'b1);
        push_beat(8'h38, 8'h78, 1'b0);
        push_beat(8'h39, 8'h79, 1'b1);
        d0 = done_cnt;
        send(4'd2, 8'h00, 8'h40);
        send(4'd1, 8'h10, 8'h50);
        send(4'd3, 8'h20, 8'h60);
        send(4'd1, 8'h30, 8'h70);
        send(4'd2, 8'h38, 8'h78);
        check("t3_lvl_full", fifo_level, 4);
        check("t3_ready_lo", ready, 0);
        check("t3_bv", beat_valid, 1);
        check("t3_src", beat_src, 8'h00);
        valid       = 1'b1;
        length      = 4'd1;
        source      = 8'hAA;
        destination = 8'hBB;
        repeat (2) begin
            @(negedge clk);
            check("t3_full_rdy", ready, 0);
            check("t3_full_lvl", fifo_level, 4);
        end
        valid = 1'b0;
        hs_cyc.delete();
        beat_ready = 1'b1;
        wait_idle(100);
        check("t3_hs", hs_cyc.size(), 9);
        if (hs_cyc.size() == 9) begin
            for (int i = 0; i < 8; i++) begin
                check("t3_gap", hs_cyc[i+1] - hs_cyc[i], gaps[i]);
            end
        end
        check("t3_done", done_cnt - d0, 5);
        check("t3_drain", exq.size(), 0);

        // 4: zero-length descriptor then a single beat
        push_beat(8'h30, 8'h50, 1'b1);
        d0 = done_cnt;
        send(4'd0, 8'h20, 8'h40);
        send(4'd1, 8'h30, 8'h50);
        check("t4_done0", desc_done, 1);
        check("t4_bv0", beat_valid, 0);
        check("t4_lvl", fifo_level, 1);
        @(negedge clk);
        check("t4_bv", beat_valid, 1);
        check("t4_src", beat_src, 8'h30);
        check("t4_dst", beat_dst, 8'h50);
        check("t4_last", beat_last, 1);
        check("t4_done_lo", desc_done, 0);
        @(negedge clk);
        check("t4_bv_end", beat_valid, 0);
        check("t4_done1", desc_done, 1);
        @(negedge clk);
        check("t4_done_cnt", done_cnt - d0, 2);

        // 5: 15 beats with random beat_ready
        beat_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            push_beat(8'(i), 8'(8'hF0 + i), i == 14);
        end
        d0 = done_cnt;
        h0 = hs_cnt;
        send(4'hF, 8'h00, 8'hF0);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (hs_cnt - h0 >= 15) break;
            beat_ready = 1'($urandom_range(0, 1));
        end
        beat_ready = 1'b1;
        wait_idle(40);
        check("t5_hs", hs_cnt - h0, 15);
        check("t5_last_dst", last_dst, 8'hFE);
        check("t5_done", done_cnt - d0, 1);

        // 6: reset mid-descriptor discards everything
        beat_ready = 1'b0;
        push_beat(8'h50, 8'h60, 1'b0);
        push_beat(8'h51, 8'h61, 1'b0);
        push_beat(8'h52, 8'h62, 1'b0);
        send(4'd8, 8'h50, 8'h60);
        send(4'd2, 8'h70, 8'h70);
        send(4'd3, 8'h80, 8'h80);
        check("t6_lvl", fifo_level, 2);
        check("t6_bv", beat_valid, 1);
        d0 = done_cnt;
        h0 = hs_cnt;
        beat_ready = 1'b1;
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        #1;
        check("t6_r_bv", beat_valid, 0);
        check("t6_r_rdy", ready, 0);
        check("t6_r_lvl", fifo_level, 0);
        check("t6_r_busy", busy, 0);
        check("t6_r_done", desc_done, 0);
        check("t6_r_src", beat_src, 0);
        check("t6_r_dst", beat_dst, 0);
        check("t6_r_last", beat_last, 0);
        check("t6_hs_pre", hs_cnt - h0, 3);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        #1;
        check("t6_rel_rdy", ready, 1);
        check("t6_rel_lvl", fifo_level, 0);
        check("t6_rel_busy", busy, 0);
        check("t6_rel_bv", beat_valid, 0);
        repeat (20) @(negedge clk);
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_no_hs", hs_cnt - h0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
